// File: rtl/spi_burst_ram.sv
// rtl/spi_burst_ram.sv - SPI slave with word RAM, command decode and auto-increment bursts
`timescale 1ns/1ps
module spi_burst_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int BURST_EN   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int PW = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
  localparam int CW = $clog2(PW + 1);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [CW-1:0]         AW_LAST   = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0]         DW_LAST   = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]         CMD_LAST  = CW'(1);

  typedef enum logic [2:0] {IDLE, CMD, RX, RD_WAIT, RD_SHIFT, DONE} state_t;
  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [CW-1:0]         cnt;
  logic [1:0]            cmd;
  logic [PW-2:0]         rx_sh;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic                  armed;

  logic [PW-1:0] rx_nx;
  logic rx_last, wr_ok, rd_ok;
  logic cnt_clr, cnt_inc, cmd_shift, rx_shift, ld_wa, ld_ra, mem_we, rd_load, tx_shift;

  assign rx_nx   = {rx_sh, MOSI};
  assign rx_last = (cmd == 2'b01) ? (cnt == DW_LAST) : (cnt == AW_LAST);
  assign wr_ok   = {1'b0, wr_addr} < DEPTH;
  assign rd_ok   = {1'b0, rd_addr} < DEPTH;

  // Out-of-range addresses keep counting through the full address space.
  function automatic logic [ADDR_WIDTH-1:0] inc_wrap(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  always_comb begin
    state_nx  = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cmd_shift = 1'b0;
    rx_shift  = 1'b0;
    ld_wa     = 1'b0;
    ld_ra     = 1'b0;
    mem_we    = 1'b0;
    rd_load   = 1'b0;
    tx_shift  = 1'b0;
    if (SS_n) begin
      state_nx = IDLE;
      cnt_clr  = 1'b1;
    end else begin
      case (state)
        IDLE: if (armed) begin
          state_nx = CMD;
          cnt_clr  = 1'b1;
        end
        CMD: begin
          cmd_shift = 1'b1;
          cnt_inc   = 1'b1;
          if (cnt == CMD_LAST) begin
            cnt_clr  = 1'b1;
            state_nx = (cmd[0] && MOSI) ? RD_WAIT : RX;
          end
        end
        RX: begin
          rx_shift = 1'b1;
          cnt_inc  = 1'b1;
          if (rx_last) begin
            cnt_clr = 1'b1;
            case (cmd)
              2'b00:   begin ld_wa = 1'b1; state_nx = DONE; end
              2'b10:   begin ld_ra = 1'b1; state_nx = DONE; end
              default: begin mem_we = 1'b1; state_nx = (BURST_EN != 0) ? RX : DONE; end
            endcase
          end
        end
        RD_WAIT: begin
          rd_load  = 1'b1;
          cnt_clr  = 1'b1;
          state_nx = RD_SHIFT;
        end
        RD_SHIFT: begin
          tx_shift = 1'b1;
          cnt_inc  = 1'b1;
          if (cnt == DW_LAST) begin
            cnt_clr  = 1'b1;
            state_nx = (BURST_EN != 0) ? RD_WAIT : DONE;
          end
        end
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_addr <= '0;
      rd_addr <= '0;
      cnt     <= '0;
      cmd     <= '0;
      rx_sh   <= '0;
      tx_sh   <= '0;
      MISO    <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state <= state_nx;
      // A frame may only start after SS_n has been seen high since reset.
      if (SS_n) armed <= 1'b1;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (cmd_shift) cmd <= {cmd[0], MOSI};
      if (rx_shift)  rx_sh <= rx_nx[PW-2:0];
      if (ld_wa)       wr_addr <= rx_nx[ADDR_WIDTH-1:0];
      else if (mem_we) wr_addr <= inc_wrap(wr_addr);
      if (ld_ra)        rd_addr <= rx_nx[ADDR_WIDTH-1:0];
      else if (rd_load) rd_addr <= inc_wrap(rd_addr);
      if (rd_load)       tx_sh <= rd_ok ? mem[rd_addr[IW-1:0]] : '0;
      else if (tx_shift) tx_sh <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
      MISO <= tx_shift & tx_sh[DATA_WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && wr_ok) mem[wr_addr[IW-1:0]] <= rx_nx[DATA_WIDTH-1:0];
  end

endmodule

// File: tb/tb_spi_burst_ram.sv
// tb/tb_spi_burst_ram.sv - randomized self-checking bench for spi_burst_ram against a word-level model
`timescale 1ns/1ps
module tb_spi_burst_ram;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ss_a = 1'b0, mosi_a = 1'b0, miso_a;
  logic ss_b = 1'b1, mosi_b = 1'b0, miso_b;

  int checks = 0;
  int errors = 0;
  int sel = 0;
  logic [15:0] ref_mem [2][256];
  int ref_wa [2];
  int ref_ra [2];

  spi_burst_ram dut_a (.clk(clk), .rst_n(rst_n), .SS_n(ss_a), .MOSI(mosi_a), .MISO(miso_a));
  spi_burst_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .MEM_DEPTH(100), .BURST_EN(0))
    dut_b (.clk(clk), .rst_n(rst_n), .SS_n(ss_b), .MOSI(mosi_b), .MISO(miso_b));

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function int dw();    return (sel != 0) ? 16 : 8;    endfunction
  function int depth(); return (sel != 0) ? 100 : 256; endfunction
  function int burst(); return (sel != 0) ? 0 : 1;     endfunction
  function int nxt(input int a); return (a == depth() - 1) ? 0 : (a + 1) % 256; endfunction
  function logic miso(); return (sel != 0) ? miso_b : miso_a; endfunction
  function logic [31:0] dut_wa(); return (sel != 0) ? 32'(dut_b.wr_addr) : 32'(dut_a.wr_addr); endfunction
  function logic [31:0] dut_ra(); return (sel != 0) ? 32'(dut_b.rd_addr) : 32'(dut_a.rd_addr); endfunction

  task automatic pins(input logic s, input logic m);
    if (sel != 0) begin ss_b = s; mosi_b = m; end
    else begin ss_a = s; mosi_a = m; end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      pins(1'b0, v[i]);
    end
  endtask

  task automatic frame_begin();
    @(negedge clk);
    pins(1'b0, 1'b0);
  endtask

  task automatic frame_end();
    @(negedge clk);
    pins(1'b1, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_wa(input int a);
    frame_begin(); send_bits(0, 2); send_bits(a, 8); frame_end();
    ref_wa[sel] = a;
  endtask

  task automatic set_ra(input int a);
    frame_begin(); send_bits(2, 2); send_bits(a, 8); frame_end();
    ref_ra[sel] = a;
  endtask

  task automatic write_words(input logic [15:0] wq [8], input int n);
    logic [15:0] w;
    frame_begin(); send_bits(1, 2);
    for (int k = 0; k < n; k++) begin
      w = wq[k] & 16'((1 << dw()) - 1);
      send_bits(w, dw());
      if (k == 0 || burst() != 0) begin
        if (ref_wa[sel] < depth()) ref_mem[sel][ref_wa[sel]] = w;
        ref_wa[sel] = nxt(ref_wa[sel]);
      end
    end
    frame_end();
  endtask

  task automatic read_words(input int n);
    logic [15:0] e;
    frame_begin(); send_bits(3, 2);
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      e = 16'h0;
      if (k == 0 || burst() != 0) begin
        if (ref_ra[sel] < depth()) e = ref_mem[sel][ref_ra[sel]];
        ref_ra[sel] = nxt(ref_ra[sel]);
      end
      @(negedge clk);
      chk("rd_gap", miso(), 0);
      for (int i = dw() - 1; i >= 0; i--) begin
        @(negedge clk);
        chk("rd_bit", miso(), e[i]);
      end
    end
    pins(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("miso_idle", miso(), 0);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_wa"}, dut_wa(), ref_wa[sel]);
    chk({tag, "_ra"}, dut_ra(), ref_ra[sel]);
  endtask

  task automatic check_mem();
    for (int i = 0; i < depth(); i++) begin
      if (sel != 0) chk("mem_b", 32'(dut_b.mem[i]), 32'(ref_mem[1][i]));
      else          chk("mem_a", 32'(dut_a.mem[i]), 32'(ref_mem[0][i]));
    end
  endtask

  task automatic random_ops(input int iters);
    logic [15:0] wq [8];
    int op, len, k;
    for (int it = 0; it < iters; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: set_wa($urandom_range(0, 255));
        1: set_ra($urandom_range(0, 255));
        2: begin
          for (int j = 0; j < 8; j++) wq[j] = 16'($urandom);
          write_words(wq, $urandom_range(1, 4));
        end
        3: read_words($urandom_range(1, 3));
        default: begin
          k = $urandom_range(0, 2);
          len = (k == 1) ? dw() : 8;
          frame_begin(); send_bits(k, 2);
          send_bits($urandom, $urandom_range(0, len - 1));
          frame_end();
        end
      endcase
      check_regs("rnd");
    end
    check_mem();
  endtask

  initial begin
    logic [15:0] wq [8];
    for (int s = 0; s < 2; s++) begin ref_wa[s] = 0; ref_ra[s] = 0; end

    // Reset held with SS_n low and MOSI toggling
    repeat (4) begin @(negedge clk); mosi_a = ~mosi_a; end
    chk("rst_miso", miso_a, 0);
    chk("rst_wa", dut_a.wr_addr, 0);
    chk("rst_ra", dut_a.rd_addr, 0);

    // Release with SS_n still low: no frame may start
    @(negedge clk); rst_n = 1'b1;
    sel = 0;
    send_bits(0, 2); send_bits(8'h33, 8);
    repeat (2) @(negedge clk);
    chk("no_arm_wa", dut_a.wr_addr, 0);
    pins(1'b1, 1'b0);
    repeat (2) @(negedge clk);

    // Preload all of memory A with one wrapping burst
    set_wa(0);
    frame_begin(); send_bits(1, 2);
    for (int i = 0; i < 256; i++) begin
      ref_mem[0][i] = 16'($urandom_range(0, 255));
      send_bits(ref_mem[0][i], 8);
    end
    frame_end();
    check_regs("preload");
    check_mem();

    // Asynchronous reset mid-frame
    set_wa(8'h40); set_ra(8'h41);
    frame_begin(); send_bits(1, 2); send_bits(4'h5, 4);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_wa", dut_a.wr_addr, 0);
    chk("async_ra", dut_a.rd_addr, 0);
    chk("async_miso", miso_a, 0);
    for (int s = 0; s < 2; s++) begin ref_wa[s] = 0; ref_ra[s] = 0; end
    repeat (3) begin @(negedge clk); mosi_a = ~mosi_a; end
    @(negedge clk); rst_n = 1'b1;
    send_bits(0, 2); send_bits(8'h5C, 8);
    chk("rearm_wa", dut_a.wr_addr, 0);
    frame_end();
    check_mem();

    // Single write
    set_wa(8'hAC);
    wq[0] = 16'h7B; write_words(wq, 1);
    chk("w1_mem", dut_a.mem[172], 8'h7B);
    chk("w1_wa", dut_a.wr_addr, 173);

    // Burst write wrapping past the top
    set_wa(8'hFF);
    wq[0] = 16'h11; wq[1] = 16'h22; write_words(wq, 2);
    chk("wrap_hi", dut_a.mem[255], 8'h11);
    chk("wrap_lo", dut_a.mem[0], 8'h22);
    chk("wrap_wa", dut_a.wr_addr, 1);
    check_mem();

    // Two-word read burst with a gap cycle
    set_wa(8'hAC);
    wq[0] = 16'h7B; wq[1] = 16'hC4; write_words(wq, 2);
    set_ra(8'hAC);
    read_words(2);
    chk("rb_ra", dut_a.rd_addr, 174);
    chk("rb_wa", dut_a.wr_addr, 174);

    // Partial data word then SS_n high
    frame_begin(); send_bits(1, 2); send_bits(4'hA, 4); frame_end();
    chk("abort_miso", miso_a, 0);
    check_regs("abort");

    // SS_n rising on the final payload edge
    frame_begin(); send_bits(1, 2); send_bits(8'h5A >> 1, 7);
    @(negedge clk); pins(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    frame_begin(); send_bits(0, 2); send_bits(8'h13 >> 1, 7);
    @(negedge clk); pins(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check_regs("late_abort");
    check_mem();

    random_ops(80);

    // Non-burst 16-bit instance with a 100-word memory
    sel = 1;
    set_wa(0);
    for (int i = 0; i < 100; i++) begin
      wq[0] = 16'($urandom);
      write_words(wq, 1);
    end
    check_regs("b_preload");
    check_mem();
    set_wa(99);
    wq[0] = 16'hBEEF; wq[1] = 16'h1234; write_words(wq, 2);
    chk("b_mem99", dut_b.mem[99], 16'hBEEF);
    chk("b_wa", dut_b.wr_addr, 0);
    set_wa(120);
    wq[0] = 16'hDEAD; write_words(wq, 1);
    chk("b_oor_wa", dut_b.wr_addr, 121);
    set_ra(120);
    read_words(2);
    chk("b_oor_ra", dut_b.rd_addr, 121);
    set_ra(98);
    read_words(2);
    check_mem();
    random_ops(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
